// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM encoding, BCD digit
// limits and the active-low seven-segment decode.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_LIMIT    = 4'd9;
  localparam logic [3:0] SEC_TENS_LIMIT = 4'd5;

  // {dp,g,f,e,d,c,b,a}, active low, dp off
  localparam logic [7:0] SEG_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam logic [7:0] SEG_DP_MASK = 8'h7F;
  localparam logic [7:0] SEG_RESET   = 8'hC0;
  localparam logic [3:0] DIG_RESET   = 4'b1110;

  function automatic logic [7:0] seg_decode(input logic [3:0] digit, input logic dp_on);
    logic [7:0] seg;
    seg = (digit > DIGIT_LIMIT) ? 8'hFF : SEG_TABLE[digit];
    if (dp_on) seg = seg & SEG_DP_MASK;
    return seg;
  endfunction

endpackage

// File: rtl/stopwatch_core_key_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, sampled debounce and a
// one-cycle pulse on each debounced press.
module key_debounce #(
  parameter int DEB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_SAMPLES);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(DEB_SAMPLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          pressed_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;

  logic sample_pressed;
  logic differs;

  assign sample_pressed = ~sync2_reg;
  assign differs        = sample_pressed != pressed_reg;

  // cnt_reg counts consecutive samples that disagree with the debounced state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      pressed_reg <= 1'b0;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sample_en) begin
        if (!differs) begin
          cnt_reg <= '0;
        end else if (cnt_reg == LAST_SAMPLE) begin
          pressed_reg <= sample_pressed;
          cnt_reg     <= '0;
          press_reg   <= sample_pressed;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/stopwatch_core.sv
// SS.CC stopwatch: divider edge detection, start/stop/clear FSM, BCD count
// and a four-digit multiplexed common-anode display driver.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int DEB_SAMPLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_100,
  input  logic        scan_400,
  input  logic        key_start_n,
  input  logic        key_clear_n,
  output logic [15:0] bcd,
  output logic        running,
  output logic        wrap,
  output logic [3:0]  dig_n,
  output logic [7:0]  seg_n
);

  logic tick_prev_reg;
  logic scan_prev_reg;
  logic cs_en;
  logic scan_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_prev_reg <= 1'b0;
      scan_prev_reg <= 1'b0;
    end else begin
      tick_prev_reg <= tick_100;
      scan_prev_reg <= scan_400;
    end
  end

  assign cs_en   = tick_100 & ~tick_prev_reg;
  assign scan_en = scan_400 & ~scan_prev_reg;

  // Key index 0 = start/stop, 1 = clear
  logic [1:0] key_raw_n;
  logic [1:0] key_press;

  assign key_raw_n = {key_clear_n, key_start_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DEB_SAMPLES(DEB_SAMPLES)
      ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(cs_en),
        .key_n    (key_raw_n[gi]),
        .press    (key_press[gi])
      );
    end
  endgenerate

  logic start_ev;
  logic clear_ev;

  assign start_ev = key_press[0];
  assign clear_ev = key_press[1];

  state_t state_reg;
  state_t state_next;
  logic   zero_count;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // In PAUSE a simultaneous clear beats start
  always_comb begin
    state_next = state_reg;
    zero_count = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start_ev) state_next = ST_RUN;
      ST_RUN:   if (start_ev) state_next = ST_PAUSE;
      ST_PAUSE: begin
        if (clear_ev) begin
          state_next = ST_IDLE;
          zero_count = 1'b1;
        end else if (start_ev) begin
          state_next = ST_RUN;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  assign running = (state_reg == ST_RUN);

  logic [15:0] count_reg;
  logic [15:0] count_next;
  logic [4:0]  carry;
  logic        wrap_reg;

  assign carry[0] = cs_en & (state_reg == ST_RUN);

  // Ripple carry through the four digits; digit 3 (sec_tens) tops out at 5
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] LIMIT = (gi == 3) ? SEC_TENS_LIMIT : DIGIT_LIMIT;
      logic [3:0] cur;
      logic       at_max;
      assign cur          = count_reg[gi*4 +: 4];
      assign at_max       = cur >= LIMIT;
      assign carry[gi+1]  = carry[gi] & at_max;
      assign count_next[gi*4 +: 4] = !carry[gi] ? cur : (at_max ? 4'd0 : cur + 4'd1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= zero_count ? 16'h0000 : count_next;
      wrap_reg  <= carry[4];
    end
  end

  assign bcd  = count_reg;
  assign wrap = wrap_reg;

  logic [1:0] idx_reg;
  logic [1:0] idx_next;
  logic [3:0] sel_digit;
  logic [3:0] dig_n_reg;
  logic [7:0] seg_n_reg;

  assign idx_next  = idx_reg + 2'd1;
  assign sel_digit = count_reg[{idx_next, 2'b00} +: 4];

  // Outputs load from the registered count, so a coincident increment shows next slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg   <= 2'd0;
      dig_n_reg <= DIG_RESET;
      seg_n_reg <= SEG_RESET;
    end else if (scan_en) begin
      idx_reg   <= idx_next;
      dig_n_reg <= ~(4'b0001 << idx_next);
      seg_n_reg <= seg_decode(sel_digit, idx_next == 2'd2);
    end
  end

  assign dig_n = dig_n_reg;
  assign seg_n = seg_n_reg;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: divider enables are driven as short
// pulses so a full minute of counting fits in a short run.
module tb_stopwatch_core;

  logic        clk;
  logic        rst_n;
  logic        tick_100;
  logic        scan_400;
  logic        key_start_n;
  logic        key_clear_n;
  logic [15:0] bcd;
  logic        running;
  logic        wrap;
  logic [3:0]  dig_n;
  logic [7:0]  seg_n;

  int pass_cnt  = 0;
  int total_cnt = 0;

  stopwatch_core #(.DEB_SAMPLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_100   (tick_100),
    .scan_400   (scan_400),
    .key_start_n(key_start_n),
    .key_clear_n(key_clear_n),
    .bcd        (bcd),
    .running    (running),
    .wrap       (wrap),
    .dig_n      (dig_n),
    .seg_n      (seg_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Returns at the negedge just after the enable pulse was sampled
  task automatic tick_start();
    repeat (2) @(negedge clk);
    tick_100 = 1'b1;
    @(negedge clk);
    tick_100 = 1'b0;
  endtask

  task automatic do_tick();
    tick_start();
    @(negedge clk);
  endtask

  task automatic do_scan();
    repeat (2) @(negedge clk);
    scan_400 = 1'b1;
    @(negedge clk);
    scan_400 = 1'b0;
  endtask

  task automatic press_keys(input logic start_k, input logic clear_k);
    key_start_n = ~start_k;
    key_clear_n = ~clear_k;
    repeat (3) do_tick();
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (3) do_tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    tick_100    = 1'b0;
    scan_400    = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_running", 16'(running), 16'h0000);
    chk("rst_wrap", 16'(wrap), 16'h0000);
    chk("rst_dig", 16'(dig_n), 16'h000E);
    chk("rst_seg", 16'(seg_n), 16'h00C0);
    rst_n = 1'b1;

    repeat (5) do_tick();
    chk("idle_ticks_bcd", bcd, 16'h0000);
    do_scan(); chk("scan1_dig", 16'(dig_n), 16'h000D); chk("scan1_seg", 16'(seg_n), 16'h00C0);
    do_scan(); chk("scan2_dig", 16'(dig_n), 16'h000B); chk("scan2_seg", 16'(seg_n), 16'h0040);
    do_scan(); chk("scan3_dig", 16'(dig_n), 16'h0007); chk("scan3_seg", 16'(seg_n), 16'h00C0);
    do_scan(); chk("scan0_dig", 16'(dig_n), 16'h000E); chk("scan0_seg", 16'(seg_n), 16'h00C0);

    // Start press: event lands one cycle after the third sample, state one later
    key_start_n = 1'b0;
    do_tick();
    do_tick();
    chk("start_2samples_running", 16'(running), 16'h0000);
    tick_start();
    chk("start_event_cycle_running", 16'(running), 16'h0000);
    @(negedge clk);
    chk("start_running", 16'(running), 16'h0001);
    key_start_n = 1'b1;
    repeat (123) do_tick();
    chk("count_0123", bcd, 16'h0123);
    chk("count_running", 16'(running), 16'h0001);

    do_scan(); chk("disp_cs_tens_dig", 16'(dig_n), 16'h000D); chk("disp_cs_tens_seg", 16'(seg_n), 16'h00A4);
    do_scan(); chk("disp_sec_ones_seg", 16'(seg_n), 16'h0079);
    do_scan(); chk("disp_sec_tens_seg", 16'(seg_n), 16'h00C0);
    do_scan(); chk("disp_cs_ones_seg", 16'(seg_n), 16'h00B0);

    repeat (5875) do_tick();
    chk("preload_5998", bcd, 16'h5998);
    do_tick();
    chk("count_5999", bcd, 16'h5999);
    chk("no_wrap_5999", 16'(wrap), 16'h0000);
    // Tick and scan coincide on the wrap: display takes the pre-increment cs_tens (9)
    repeat (2) @(negedge clk);
    tick_100 = 1'b1;
    scan_400 = 1'b1;
    @(negedge clk);
    tick_100 = 1'b0;
    scan_400 = 1'b0;
    chk("wrap_bcd", bcd, 16'h0000);
    chk("wrap_pulse", 16'(wrap), 16'h0001);
    chk("coinc_dig", 16'(dig_n), 16'h000D);
    chk("coinc_seg", 16'(seg_n), 16'h0090);
    @(negedge clk);
    chk("wrap_one_cycle", 16'(wrap), 16'h0000);
    chk("wrap_keeps_running", 16'(running), 16'h0001);
    do_scan();
    chk("post_wrap_sec_ones_seg", 16'(seg_n), 16'h0040);

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("rst2_bcd", bcd, 16'h0000);
    chk("rst2_running", 16'(running), 16'h0000);

    press_keys(1'b1, 1'b0);
    chk("run_after_release_bcd", bcd, 16'h0003);
    repeat (44) do_tick();
    press_keys(1'b1, 1'b0);
    chk("pause_bcd", bcd, 16'h0050);
    chk("pause_running", 16'(running), 16'h0000);
    repeat (20) do_tick();
    chk("pause_frozen", bcd, 16'h0050);
    press_keys(1'b0, 1'b1);
    chk("clear_bcd", bcd, 16'h0000);
    chk("clear_running", 16'(running), 16'h0000);

    press_keys(1'b1, 1'b0);
    press_keys(1'b1, 1'b0);
    chk("pause2_bcd", bcd, 16'h0006);
    press_keys(1'b1, 1'b1);
    chk("both_bcd", bcd, 16'h0000);
    chk("both_not_run", 16'(running), 16'h0000);
    repeat (5) do_tick();
    chk("both_idle_stays", bcd, 16'h0000);
    press_keys(1'b1, 1'b0);
    press_keys(1'b0, 1'b1);
    chk("clear_in_run_bcd", bcd, 16'h0009);
    chk("clear_in_run_running", 16'(running), 16'h0001);

    for (int i = 0; i < 10; i++) begin
      key_start_n = (i % 2 == 1);
      do_tick();
    end
    key_start_n = 1'b1;
    chk("bounce_bcd", bcd, 16'h0019);
    chk("bounce_running", 16'(running), 16'h0001);

    repeat (23) do_tick();
    chk("count_0042", bcd, 16'h0042);
    do_scan();
    chk("pre_rst_dig", 16'(dig_n), 16'h000D);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("rst3_bcd", bcd, 16'h0000);
    chk("rst3_running", 16'(running), 16'h0000);
    chk("rst3_wrap", 16'(wrap), 16'h0000);
    chk("rst3_dig", 16'(dig_n), 16'h000E);
    chk("rst3_seg", 16'(seg_n), 16'h00C0);
    rst_n = 1'b1;
    do_tick();
    chk("rst3_idle_after", bcd, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
